arbiter_rr_4: RTL and testbench

//  Round-robin arbiter for 4 requesters with grant locking and an optional hold-time limit.

---
 rtl/arbiter_rr_4.sv | 99 +++++++++
 tb/tb_arbiter_rr_4.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_4.sv
// Round-robin arbiter for 4 requesters with grant locking and an optional hold-time limit.
// Also provides decoder_2_4, which turns the granted index into per-requester grant lines.
module arbiter_rr_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_req,
  output logic       o_grant_valid,
  output logic [1:0] o_grant_idx
);

  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    last_ptr_q, last_ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    winner, cand;
  logic          found;
  logic [3:0]    others;
  logic          preempt;

  // Search starts just after the previous owner, so it gets lowest priority.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_ptr_q + 2'(k);
      if (!found && i_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    others  = i_req & ~(4'b0001 << idx_q);
    preempt = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && (others != '0);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_ptr_d = last_ptr_q;
    hold_d     = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = winner;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!i_req[idx_q] || preempt) begin
          state_d    = IDLE;
          last_ptr_d = idx_q;
        end else if (others == '0) begin
          hold_d = '0;
        end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_ptr_q <= 2'b11;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_ptr_q <= last_ptr_d;
      hold_q     <= hold_d;
    end
  end

  assign o_grant_valid = (state_q == GRANT);
  assign o_grant_idx   = idx_q;

endmodule

module decoder_2_4 (
  input  logic [1:0] i_binary,
  output logic [3:0] o_onehot
);

  assign o_onehot = 4'b0001 << i_binary;

endmodule

// File: tb/tb_arbiter_rr_4.sv
// Self-checking bench for arbiter_rr_4: expected {valid,idx} per cycle are queued as
// stimulus is driven and popped after the following clock edge.
module tb_arbiter_rr_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       gv, gv1;
  logic [1:0] gi, gi1;
  logic [3:0] onehot;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp1_q[$];

  arbiter_rr_4 #(.MAX_HOLD(4)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .o_grant_valid(gv), .o_grant_idx(gi)
  );

  arbiter_rr_4 #(.MAX_HOLD(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_req(req), .o_grant_valid(gv1), .o_grant_idx(gi1)
  );

  decoder_2_4 u_dec (.i_binary(gi), .o_onehot(onehot));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant-line decode and granted-request checks, sampled mid-cycle.
  logic       prev_gv  = 1'b0;
  logic [3:0] prev_req = '0;
  logic [3:0] exp_oh;
  always @(negedge clk) begin
    if (!rst) begin
      if (gv) begin
        case (gi)
          2'd0: exp_oh = 4'b0001;
          2'd1: exp_oh = 4'b0010;
          2'd2: exp_oh = 4'b0100;
          default: exp_oh = 4'b1000;
        endcase
        checks++;
        if (onehot !== exp_oh) begin
          errors++;
          $display("FAIL decoder: onehot=%b required %b (idx=%0d)", onehot, exp_oh, gi);
        end
        if (!prev_gv) begin
          checks++;
          if (prev_req[gi] !== 1'b1) begin
            errors++;
            $display("FAIL granted_bit: idx=%0d granted but req at granting edge=%b", gi, prev_req);
          end
        end
      end
    end
    prev_gv  = rst ? 1'b0 : gv;
    prev_req = req;
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(3'b000);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gv !== e[2] || gi !== e[1:0]) begin
        errors++;
        $display("FAIL reset_hold: valid=%b idx=%0d, required valid=%b idx=%0d", gv, gi, e[2], e[1:0]);
      end
    end
    rst = 1'b0;
    exp_q.push_back(3'b100);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (gv !== e[2] || gi !== e[1:0]) begin
      errors++;
      $display("FAIL reset_first_grant: valid=%b idx=%0d, required valid=%b idx=%0d", gv, gi, e[2], e[1:0]);
    end
    req = 4'b0000;
    exp_q.push_back(3'b000);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (gv !== e[2]) begin
      errors++;
      $display("FAIL reset_release: valid=%b, required %b", gv, e[2]);
    end
  endtask

  task automatic test_single();
    logic [3:0] reqs [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    logic [2:0] exps [6] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b000};
    logic [2:0] e;
    for (int i = 0; i < 6; i++) begin
      req = reqs[i];
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gv !== e[2] || (e[2] && gi !== e[1:0])) begin
        errors++;
        $display("FAIL single step %0d: valid=%b idx=%0d, required valid=%b idx=%0d", i, gv, gi, e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] reqs [14] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1101, 4'b1111,
                              4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111, 4'b1111, 4'b0000};
    logic [2:0] exps [14] = '{3'b100, 3'b100, 3'b000, 3'b101, 3'b101, 3'b000, 3'b110,
                              3'b110, 3'b000, 3'b111, 3'b111, 3'b000, 3'b100, 3'b000};
    logic [2:0] e;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      req = reqs[i];
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gv !== e[2] || (e[2] && gi !== e[1:0])) begin
        errors++;
        $display("FAIL rotation step %0d: valid=%b idx=%0d, required valid=%b idx=%0d", i, gv, gi, e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] reqs [5] = '{4'b1000, 4'b1000, 4'b0001, 4'b1001, 4'b0000};
    logic [2:0] exps [5] = '{3'b111, 3'b111, 3'b000, 3'b100, 3'b000};
    logic [2:0] e;
    for (int i = 0; i < 5; i++) begin
      req = reqs[i];
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gv !== e[2] || (e[2] && gi !== e[1:0])) begin
        errors++;
        $display("FAIL wrap step %0d: valid=%b idx=%0d, required valid=%b idx=%0d", i, gv, gi, e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_preempt();
    logic [3:0] reqs [12] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                              4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
    logic [2:0] exp4 [12] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b101,
                              3'b101, 3'b101, 3'b101, 3'b000, 3'b100, 3'b000};
    logic [2:0] exp1 [12] = '{3'b100, 3'b000, 3'b101, 3'b000, 3'b100, 3'b000,
                              3'b101, 3'b000, 3'b100, 3'b000, 3'b101, 3'b000};
    logic [2:0] e, e1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = reqs[i];
      exp_q.push_back(exp4[i]);
      exp1_q.push_back(exp1[i]);
      @(posedge clk); #1;
      e  = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      checks++;
      if (gv !== e[2] || (e[2] && gi !== e[1:0])) begin
        errors++;
        $display("FAIL preempt_max4 step %0d: valid=%b idx=%0d, required valid=%b idx=%0d", i, gv, gi, e[2], e[1:0]);
      end
      checks++;
      if (gv1 !== e1[2] || (e1[2] && gi1 !== e1[1:0])) begin
        errors++;
        $display("FAIL preempt_max1 step %0d: valid=%b idx=%0d, required valid=%b idx=%0d", i, gv1, gi1, e1[2], e1[1:0]);
      end
    end
  endtask

  task automatic test_hold_reset();
    logic [3:0] reqs [10] = '{4'b0001, 4'b0011, 4'b0011, 4'b0001, 4'b0011,
                              4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
    logic [2:0] exps [10] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                              3'b100, 3'b100, 3'b000, 3'b101, 3'b000};
    logic [2:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = reqs[i];
      exp_q.push_back(exps[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gv !== e[2] || (e[2] && gi !== e[1:0])) begin
        errors++;
        $display("FAIL hold_reset step %0d: valid=%b idx=%0d, required valid=%b idx=%0d", i, gv, gi, e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_alone_async_reset();
    logic [2:0] e;
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(3'b101);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (gv !== e[2] || gi !== e[1:0]) begin
        errors++;
        $display("FAIL alone step %0d: valid=%b idx=%0d, required valid=%b idx=%0d", i, gv, gi, e[2], e[1:0]);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gv !== 1'b0 || gi !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b idx=%0d, required valid=0 idx=0", gv, gi);
    end
    req = 4'b1001;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(3'b100);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (gv !== e[2] || gi !== e[1:0]) begin
      errors++;
      $display("FAIL post_reset_search: valid=%b idx=%0d, required valid=%b idx=%0d", gv, gi, e[2], e[1:0]);
    end
    req = 4'b0000;
    exp_q.push_back(3'b000);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (gv !== e[2]) begin
      errors++;
      $display("FAIL post_reset_release: valid=%b, required %b", gv, e[2]);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b1111;
    #2;
    rst = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_preempt();
    test_hold_reset();
    test_alone_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
